// File: rtl/jtag_master.sv
// jtag_master: simple IEEE 1149.1 scan master.
//
// After reset it walks the target TAP into Run-Test/Idle. Each accepted command
// performs one DR or IR scan from Run-Test/Idle and returns to Run-Test/Idle.
// One FSM step is exactly one TCK period. TCK is low for the first half of the
// step and high for the second half.
//
// Ports
//   clk    : system clock, all logic on rising edge
//   rst    : asynchronous active-high reset
//   start  : command request, looked at only in IDLE
//   ir_sel : 0 = DR scan, 1 = IR scan (latched with start)
//   len    : scan length, 1..32; 0 or >32 means 32 (latched with start)
//   wdata  : shift-in data, LSB first (latched with start)
//   rdata  : captured TDO bits, bit 0 = first captured; unused upper bits are 0
//   busy   : reset sequence or command in progress
//   done   : one-clk pulse on command completion
//   tck    : generated JTAG clock, period 2*CLK_DIV clk cycles
//   tms    : JTAG mode select
//   tdi    : JTAG data to target
//   tdo    : JTAG data from target
module jtag_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ir_sel,
  input  logic [5:0]  len,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_NAV   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_EXIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_div;
  logic        r_tck;
  logic [5:0]  r_step;
  logic        r_ir;
  logic [5:0]  r_len;
  logic [31:0] r_wdata;
  logic [31:0] r_cap;
  logic [31:0] r_rdata;

  logic        w_stepping;
  logic        w_rise;
  logic        w_fall;
  logic        w_step_last;
  logic        w_tms;
  logic        w_tdi;
  logic [5:0]  w_len_eff;

  assign w_len_eff  = (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
  assign w_stepping = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_rise     = w_stepping && (r_div == DIV_LAST) && !r_tck;
  assign w_fall     = w_stepping && (r_div == DIV_LAST) && r_tck;

  // TMS/TDI are decoded from the current step, so they only move when the step
  // advances, which happens on the same clk edge that drops TCK.
  always_comb begin
    w_tms       = 1'b0;
    w_tdi       = 1'b0;
    w_step_last = 1'b0;
    case (r_state)
      S_RST: begin
        w_tms       = (r_step < 6'd5);
        w_step_last = (r_step == 6'd5);
      end
      S_NAV: begin
        // DR: Select-DR, Capture-DR, Shift-DR; IR adds Select-IR.
        w_tms       = r_ir ? (r_step < 6'd2) : (r_step == 6'd0);
        w_step_last = (r_step == (r_ir ? 6'd3 : 6'd2));
      end
      S_SHIFT: begin
        w_step_last = (r_step == r_len - 6'd1);
        w_tms       = w_step_last;
        w_tdi       = r_wdata[r_step[4:0]];
      end
      S_EXIT: begin
        w_tms       = (r_step == 6'd0);
        w_step_last = (r_step == 6'd1);
      end
      default: ;
    endcase
  end

  // Control: FSM, TCK divider, step counter, command attributes, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
      r_div   <= 8'd0;
      r_tck   <= 1'b0;
      r_step  <= 6'd0;
      r_ir    <= 1'b0;
      r_len   <= 6'd32;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_NAV;
            r_ir    <= ir_sel;
            r_len   <= w_len_eff;
            r_step  <= 6'd0;
            r_div   <= 8'd0;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= 8'd0;
            r_tck <= ~r_tck;
            if (r_tck) begin
              if (!w_step_last) begin
                r_step <= r_step + 6'd1;
              end else begin
                r_step <= 6'd0;
                case (r_state)
                  S_RST:   r_state <= S_IDLE;
                  S_NAV:   r_state <= S_SHIFT;
                  S_SHIFT: r_state <= S_EXIT;
                  default: begin
                    r_state <= S_DONE;
                    r_rdata <= r_cap;
                  end
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  // Data: shift-in word and capture register. The capture register is
  // cleared per command so bits beyond len read back as 0.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_wdata <= wdata;
      r_cap   <= 32'd0;
    end else if (w_rise && r_state == S_SHIFT) begin
      r_cap[r_step[4:0]] <= tdo;
    end
  end

  assign tck   = r_tck;
  assign tms   = w_tms;
  assign tdi   = w_tdi;
  assign busy  = w_stepping;
  assign done  = (r_state == S_DONE);
  assign rdata = r_rdata;

  // w_fall is kept for readability of the step timing; it mirrors the
  // branch taken above when r_tck is high at the end of a half period.
  logic w_fall_unused;
  assign w_fall_unused = w_fall;

endmodule

// File: tb/tb_jtag_master.sv
`timescale 1ns/1ps
module tb_jtag_master;
  localparam int CLK_DIV = 2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        ir_sel = 1'b0;
  logic [5:0]  len    = 6'd0;
  logic [31:0] wdata  = 32'd0;
  logic [31:0] rdata;
  logic        busy, done, tck, tms, tdi, tdo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtag_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .ir_sel(ir_sel), .len(len),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // ---------------- target TAP model (standard 16-state controller) ----------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap_st      = TLR;
  logic [31:0] tap_preload = 32'h12345678;
  logic [31:0] tap_dr      = 32'd0;
  logic [31:0] tap_dsh     = 32'd0;
  logic [31:0] tap_ish     = 32'd0;
  logic        tap_tdo     = 1'b0;
  int          tdo_mode    = 1;   // 0 tie low, 1 tie high, 2 TAP model

  assign tdo = (tdo_mode == 2) ? tap_tdo : (tdo_mode == 1);

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR:   tap_dr  <= tap_preload;
      CAPDR: tap_dsh <= tap_dr;
      SHDR:  tap_dsh <= {tdi, tap_dsh[31:1]};
      UPDR:  tap_dr  <= tap_dsh;
      CAPIR: tap_ish <= 32'h1;
      SHIR:  tap_ish <= {tdi, tap_ish[31:1]};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tap_tdo <= (tap_st == SHDR) ? tap_dsh[0] : (tap_st == SHIR) ? tap_ish[0] : 1'b0;

  // ---------------- expected TCK-edge sequence model --------------------------
  bit          exp_tms_q[$];
  bit          exp_tdi_q[$];
  bit          exp_chk_q[$];
  int          seq_pos   = 0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_step(input bit m, input bit d, input bit c);
    exp_tms_q.push_back(m);
    exp_tdi_q.push_back(d);
    exp_chk_q.push_back(c);
  endtask

  task automatic model_rst();
    exp_tms_q.delete(); exp_tdi_q.delete(); exp_chk_q.delete();
    seq_pos = 0;
    for (int i = 0; i < 6; i++) push_step(i < 5, 1'b0, 1'b1);
  endtask

  task automatic model_cmd(input bit ir, input int n, input logic [31:0] w);
    exp_tms_q.delete(); exp_tdi_q.delete(); exp_chk_q.delete();
    seq_pos = 0;
    push_step(1'b1, 1'b0, 1'b0);
    if (ir) push_step(1'b1, 1'b0, 1'b0);
    push_step(1'b0, 1'b0, 1'b0);
    push_step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) push_step(i == n - 1, w[i], 1'b1);
    push_step(1'b1, 1'b0, 1'b0);
    push_step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] f_mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // ---------------- compare process (every falling clk edge) ------------------
  int          edges = 0;
  int          dones = 0;
  int          hi_run = 0;
  int          since_rise = 0;
  logic        prev_tck = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_rdata = 32'd0;
  logic [63:0] tms_log = 64'd0;
  logic [63:0] tdi_log = 64'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_tck   = 1'b0;
      prev_done  = 1'b0;
      prev_rdata = 32'd0;
      hi_run     = 0;
      since_rise = 0;
    end else begin
      since_rise++;
      if (tck) hi_run++;
      if (tck && !prev_tck) begin
        edges++;
        tms_log = {tms_log[62:0], tms};
        tdi_log = {tdi_log[62:0], tdi};
        n_cmp++;
        if (exp_tms_q.size() == 0) begin
          n_err++;
          $display("FAIL tck_edge: got an unexpected rising edge, expected none at %0t", $time);
        end else begin
          if (seq_pos > 0) check("tck_period", since_rise, 2 * CLK_DIV);
          check("tms_at_rise", tms, exp_tms_q.pop_front());
          if (exp_chk_q.pop_front()) check("tdi_at_rise", tdi, exp_tdi_q.pop_front());
          else void'(exp_tdi_q.pop_front());
          seq_pos++;
        end
        since_rise = 0;
      end
      if (!tck && prev_tck) begin
        check("tck_high_time", hi_run, CLK_DIV);
        hi_run = 0;
      end
      if (!busy) check("idle_pins", {29'd0, tck, tms, tdi}, 32'd0);
      if (done) begin
        dones++;
        check("done_busy", busy, 1'b0);
        check("done_width", prev_done, 1'b0);
        check("done_rdata", rdata, exp_rdata);
        check("done_edges_left", exp_tms_q.size(), 0);
        check("done_tap_rti", tap_st == RTI, 1'b1);
      end else begin
        check("rdata_hold", rdata, prev_rdata);
      end
      prev_tck   = tck;
      prev_done  = done;
      prev_rdata = rdata;
    end
  end

  // ---------------- stimulus --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit ir, input logic [5:0] l, input logic [31:0] w,
                       input logic [31:0] er);
    int n;
    n = (l == 6'd0 || l > 6'd32) ? 32 : int'(l);
    model_cmd(ir, n, w);
    exp_rdata = er;
    edges = 0; dones = 0; tms_log = 64'd0; tdi_log = 64'd0;
    ir_sel = ir; len = l; wdata = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and reset sequence
    tdo_mode = 1;
    model_rst();
    repeat (3) tick();
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    edges = 0; tms_log = 64'd0;
    rst = 1'b0;
    wait_idle(200);
    tick();
    check("rstseq_edges", edges, 6);
    check("rstseq_tms", tms_log[5:0], 6'b111110);
    check("rstseq_tck_low", tck, 1'b0);
    check("rstseq_tap_rti", tap_st == RTI, 1'b1);

    // 32-bit DR scan (len=0) against the TAP model
    tdo_mode = 2;
    issue(1'b0, 6'd0, 32'hDEADBEEF, tap_preload);
    check("cmd_busy", busy, 1'b1);
    wait_done(1000);
    tick();
    check("dr32_edges", edges, 37);
    check("dr32_dones", dones, 1);
    check("dr32_rdata", rdata, 32'h12345678);
    check("dr32_tap_dr", tap_dr, 32'hDEADBEEF);

    // DR len 8, tdo high, with a stray start while busy
    tdo_mode = 1;
    issue(1'b0, 6'd8, 32'h000000A5, f_mask(8));
    repeat (10) tick();
    ir_sel = 1'b1; len = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000);
    tick();
    check("dr8_edges", edges, 13);
    check("dr8_tms", tms_log[12:0], 13'b1000000000110);
    check("dr8_tdi", tdi_log[9:2], 8'b10100101);
    check("dr8_rdata", rdata, 32'h000000FF);
    check("dr8_dones", dones, 1);
    repeat (4) tick();
    check("dr8_not_queued", busy, 1'b0);

    // IR len 4, tdo low
    tdo_mode = 0;
    issue(1'b1, 6'd4, 32'h3, 32'd0);
    wait_done(1000);
    tick();
    check("ir4_edges", edges, 10);
    check("ir4_tms", tms_log[9:0], 10'b1100000110);
    check("ir4_rdata", rdata, 32'd0);
    check("ir4_dones", dones, 1);

    // Back-to-back: start in the clk right after done
    tdo_mode = 1;
    issue(1'b0, 6'd5, 32'h15, f_mask(5));
    check("b2b_accept", busy, 1'b1);
    wait_done(1000);
    // start during the DONE cycle must be ignored
    ir_sel = 1'b0; len = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("done_start_ignored", busy, 1'b0);
    check("b2b_dones", dones, 1);
    check("b2b_rdata", rdata, 32'h0000001F);

    // Abort at the 4th SHIFT bit
    issue(1'b0, 6'd8, 32'hFF, f_mask(8));
    for (int i = 0; i < 200 && edges < 7; i++) tick();
    check("abort_reach_bit4", edges, 7);
    rst = 1'b1;
    model_rst();
    #1;
    check("abort_tck", tck, 1'b0);
    check("abort_tms", tms, 1'b1);
    check("abort_busy", busy, 1'b1);
    check("abort_rdata", rdata, 32'd0);
    check("abort_done", done, 1'b0);
    repeat (3) tick();
    edges = 0; tms_log = 64'd0;
    rst = 1'b0;
    wait_idle(200);
    tick();
    check("abort_rstseq_edges", edges, 6);
    check("abort_rstseq_tms", tms_log[5:0], 6'b111110);
    check("abort_no_done", dones, 0);
    check("abort_tap_rti", tap_st == RTI, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
